// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared shift-op encoding and the split of shift steps per stage.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    RSVD = 2'b10,
    SRA  = 2'b11
  } shift_op_t;

  // Earlier stages absorb the remainder when steps do not divide evenly.
  function automatic int steps_in_stage(int total, int stages, int idx);
    return total / stages + ((idx < total % stages) ? 1 : 0);
  endfunction

  function automatic int first_step(int total, int stages, int idx);
    int lo = 0;
    for (int j = 0; j < idx; j++) lo += steps_in_stage(total, stages, j);
    return lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_stage
// Brief    : One pipeline stage applying right-shift steps FIRST..LAST.
// Revision : 1.0 - initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5,
  parameter int FIRST = 0,
  parameter int LAST  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic                    in_fill,
  input  shift_op_t               in_op,
  input  logic                    in_word,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [$clog2(XLEN)-1:0] out_shamt,
  output logic                    out_fill,
  output shift_op_t               out_op,
  output logic                    out_word,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHW = $clog2(XLEN);

  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        data_q, data_d;
  logic [SHW-1:0]         shamt_q, shamt_d;
  logic                   fill_q, fill_d;
  shift_op_t              op_q, op_d;
  logic                   word_q, word_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [XLEN-1:0]        shifted;
  logic signed [XLEN:0]   ext;
  logic                   load;

  always_comb begin
    shifted = in_data;
    ext     = '0;
    for (int k = FIRST; k <= LAST; k++) begin
      if (in_shamt[k]) begin
        ext     = $signed({in_fill, shifted}) >>> (1 << k);
        shifted = ext[XLEN-1:0];
      end
    end

    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = flush ? 1'b0 : (in_ready ? in_valid : valid_q);
    data_d   = load ? shifted  : data_q;
    shamt_d  = load ? in_shamt : shamt_q;
    fill_d   = load ? in_fill  : fill_q;
    op_d     = load ? in_op    : op_q;
    word_d   = load ? in_word  : word_q;
    tag_d    = load ? in_tag   : tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
      op_q    <= SLL;
      word_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      fill_q  <= fill_d;
      op_q    <= op_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_fill  = fill_q;
  assign out_op    = op_q;
  assign out_word  = word_q;
  assign out_tag   = tag_q;

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe
// Brief    : Pipelined SLL/SRL/SRA unit with RV64 word mode, flush and tags.
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe
  import shift_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_a,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [1:0]              in_op,
  input  logic                    in_word,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] LO32_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

  logic [STAGES:0]              valid_c;
  logic [STAGES:0]              ready_c;
  logic [STAGES:0][XLEN-1:0]    data_c;
  logic [STAGES:0][SHW-1:0]     shamt_c;
  logic [STAGES:0]              fill_c;
  logic [STAGES:0]              word_c;
  logic [STAGES:0][TAG_W-1:0]   tag_c;
  shift_op_t                    op_c [STAGES+1];

  shift_op_t       op_in;
  logic            word_mode;
  logic            fill_in;
  logic [XLEN-1:0] a_cond;
  logic [XLEN-1:0] data_in;
  logic [SHW-1:0]  shamt_in;
  logic [XLEN-1:0] tail;
  logic [XLEN-1:0] result;
  logic [SHW-1:0]  spent_shamt_unused;
  logic            spent_fill_unused;

  // Every op becomes a right shift: SLL is bit-reversed on entry and exit.
  always_comb begin
    op_in     = shift_op_t'(in_op);
    word_mode = (XLEN == 64) && in_word;
    fill_in   = 1'b0;
    if (op_in == SRA) fill_in = word_mode ? in_a[31] : in_a[XLEN-1];
    a_cond   = word_mode ? ((in_a & LO32_MASK) | ({XLEN{fill_in}} & ~LO32_MASK)) : in_a;
    data_in  = a_cond;
    if (op_in == SLL) begin
      for (int i = 0; i < XLEN; i++) data_in[i] = a_cond[XLEN-1-i];
    end
    shamt_in = word_mode ? (in_shamt & SHW'(31)) : in_shamt;
  end

  assign valid_c[0]      = in_valid && !flush;
  assign data_c[0]       = data_in;
  assign shamt_c[0]      = shamt_in;
  assign fill_c[0]       = fill_in;
  assign op_c[0]         = op_in;
  assign word_c[0]       = word_mode;
  assign tag_c[0]        = in_tag;
  assign ready_c[STAGES] = out_ready;
  assign in_ready        = ready_c[0] && !flush;

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int FIRST = first_step(SHW, STAGES, s);
      localparam int LAST  = FIRST + steps_in_stage(SHW, STAGES, s) - 1;

      shift_stage #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W),
        .FIRST (FIRST),
        .LAST  (LAST)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (valid_c[s]),
        .in_ready  (ready_c[s]),
        .in_data   (data_c[s]),
        .in_shamt  (shamt_c[s]),
        .in_fill   (fill_c[s]),
        .in_op     (op_c[s]),
        .in_word   (word_c[s]),
        .in_tag    (tag_c[s]),
        .out_valid (valid_c[s+1]),
        .out_ready (ready_c[s+1]),
        .out_data  (data_c[s+1]),
        .out_shamt (shamt_c[s+1]),
        .out_fill  (fill_c[s+1]),
        .out_op    (op_c[s+1]),
        .out_word  (word_c[s+1]),
        .out_tag   (tag_c[s+1])
      );
    end
  endgenerate

  // Shift amount and fill are fully consumed by the last stage.
  assign spent_shamt_unused = shamt_c[STAGES];
  assign spent_fill_unused  = fill_c[STAGES];

  always_comb begin
    tail   = data_c[STAGES];
    result = tail;
    if (op_c[STAGES] == SLL) begin
      for (int i = 0; i < XLEN; i++) result[i] = tail[XLEN-1-i];
    end
    if (word_c[STAGES]) result = (result & LO32_MASK) | ({XLEN{result[31]}} & ~LO32_MASK);
    if (op_c[STAGES] == RSVD) result = '0;
  end

  assign out_valid  = valid_c[STAGES];
  assign out_result = result;
  assign out_tag    = tag_c[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Self-checking bench for shift_pipe (XLEN=64, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid, in_ready, in_word, flush, out_valid, out_ready;
  logic [XLEN-1:0]   in_a, out_result;
  logic [5:0]        in_shamt;
  logic [1:0]        in_op;
  logic [TAG_W-1:0]  in_tag, out_tag;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t q[$];

  shift_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: plain shift operators on 64- or 32-bit values.
  function automatic logic [XLEN-1:0] ref_shift(logic [XLEN-1:0] a, logic [5:0] sh,
                                                 logic [1:0] op, logic word);
    logic [31:0]     a32;
    logic [31:0]     r32;
    logic [XLEN-1:0] r;
    a32 = a[31:0];
    r32 = '0;
    r   = '0;
    if (op == 2'b10) return '0;
    if (word) begin
      case (op)
        2'b00:   r32 = a32 << sh[4:0];
        2'b01:   r32 = a32 >> sh[4:0];
        default: r32 = $signed(a32) >>> sh[4:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        2'b00:   r = a << sh;
        2'b01:   r = a >> sh;
        default: r = $signed(a) >>> sh;
      endcase
    end
    return r;
  endfunction

  task automatic drive_rand(input logic [TAG_W-1:0] tag);
    in_a     = {$urandom, $urandom};
    in_shamt = 6'($urandom_range(0, 63));
    in_op    = 2'($urandom_range(0, 3));
    in_word  = ($urandom_range(0, 3) == 0);
    in_tag   = tag;
  endtask

  task automatic run_one(input string name, input logic [XLEN-1:0] a, input logic [5:0] sh,
                         input logic [1:0] op, input logic word, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] exp);
    in_a = a; in_shamt = sh; in_op = op; in_word = word; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept: in_ready got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s early: out_valid got %b want 0", name, out_valid);
    end
    @(posedge clk); #2;
    vectors++;
    if (out_valid !== 1'b1 || out_result !== exp || out_tag !== tag) begin
      errors++;
      $display("FAIL %s result: got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
               name, out_valid, out_result, out_tag, exp, tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b r=%h t=%0d want v=0 rdy=1 r=0 t=0",
               out_valid, in_ready, out_result, out_tag);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_directed();
    run_one("srl63",  64'h8000_0000_0000_0000, 6'd63, 2'b01, 1'b0, 5'd1, 64'h0000_0000_0000_0001);
    run_one("sra_neg",64'h8000_0000_0000_0000, 6'd4,  2'b11, 1'b0, 5'd2, 64'hF800_0000_0000_0000);
    run_one("sra_pos",64'h7000_0000_0000_0000, 6'd4,  2'b11, 1'b0, 5'd3, 64'h0700_0000_0000_0000);
    run_one("sllw",   64'h0000_0000_0000_0001, 6'd31, 2'b00, 1'b1, 5'd4, 64'hFFFF_FFFF_8000_0000);
    run_one("sraw",   64'h0000_0000_8000_0000, 6'd31, 2'b11, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("srlw",   64'hFFFF_FFFF_FFFF_FFFF, 6'd4,  2'b01, 1'b1, 5'd6, 64'h0000_0000_0FFF_FFFF);
    run_one("sll63",  64'h0000_0000_0000_0001, 6'd63, 2'b00, 1'b0, 5'd7, 64'h8000_0000_0000_0000);
    run_one("shamt0", 64'h1234_5678_9ABC_DEF0, 6'd0,  2'b11, 1'b0, 5'd8, 64'h1234_5678_9ABC_DEF0);
    run_one("rsvd",   64'hDEAD_BEEF_CAFE_F00D, 6'd5,  2'b10, 1'b0, 5'd9, 64'h0);
  endtask

  task automatic test_random();
    logic            stalled = 1'b0;
    logic [XLEN-1:0] held_res = '0;
    logic [TAG_W-1:0] held_tag = '0;
    exp_t e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      flush     = 1'b0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand(TAG_W'(cyc));
      #1;
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
          errors++;
          $display("FAIL hold: got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                   out_valid, out_result, out_tag, held_res, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          errors++; $display("FAIL spurious: got tag %0d want no output", out_tag);
        end else begin
          e = q.pop_front();
          if (out_result !== e.res || out_tag !== e.tag) begin
            errors++;
            $display("FAIL random: got r=%h t=%0d want r=%h t=%0d", out_result, out_tag, e.res, e.tag);
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{ref_shift(in_a, in_shamt, in_op, in_word), in_tag});
      stalled  = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        vectors++;
        if (out_result !== e.res || out_tag !== e.tag) begin
          errors++;
          $display("FAIL drain: got r=%h t=%0d want r=%h t=%0d", out_result, out_tag, e.res, e.tag);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain_count: got %0d pending want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_back_to_back();
    int   acc = 0;
    int   got = 0;
    int   nt  = 1;
    exp_t e;
    flush = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (nt <= 4);
      drive_rand(TAG_W'(nt));
      in_word = 1'b0;
      #1;
      if (cyc == 2) begin
        vectors++;
        if (in_ready !== 1'b0 || acc != 2) begin
          errors++; $display("FAIL bp_ready: got rdy=%b acc=%0d want rdy=0 acc=2", in_ready, acc);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        e = (q.size() > 0) ? q.pop_front() : '0;
        if (out_tag !== TAG_W'(got + 1) || out_result !== e.res) begin
          errors++;
          $display("FAIL bp_order: got r=%h t=%0d want r=%h t=%0d", out_result, out_tag, e.res, got + 1);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{ref_shift(in_a, in_shamt, in_op, in_word), in_tag});
        acc++;
        nt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (got != 4) begin
      errors++; $display("FAIL bp_count: got %0d results want 4", got);
    end
    q.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; drive_rand(TAG_W'(20 + k));
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; drive_rand(5'd22);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_drop: got out_valid %b tag %0d want 0", out_valid, out_tag);
      end
      @(posedge clk); #1;
    end
    // Flush with an empty pipe must still refuse the offered input.
    flush = 1'b1; in_valid = 1'b1; drive_rand(5'd23);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_empty_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_empty_drop: got out_valid %b want 0", out_valid);
      end
      @(posedge clk); #1;
    end
    run_one("post_flush", 64'h0000_0000_0000_00F0, 6'd4, 2'b01, 1'b0, 5'd24, 64'h0000_0000_0000_000F);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; drive_rand(TAG_W'(26 + k));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_one("post_rst", 64'hFFFF_0000_FFFF_0000, 6'd16, 2'b11, 1'b0, 5'd30, 64'hFFFF_FFFF_0000_FFFF);
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_stale: got out_valid %b tag %0d want 0", out_valid, out_tag);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; in_word = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width; legal values are 32 and 64.
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline depth; legal range is 1..log2(XLEN).
REQ-003 SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag (destination register index).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept the offered operation.
REQ-008 SHALL have port in_a, input, XLEN bits: the operand to shift.
REQ-009 SHALL have port in_shamt, input, log2(XLEN) bits: the shift amount.
REQ-010 SHALL have port in_op, input, 2 bits: the shift operation, encoded as a shift_op_t value.
REQ-011 SHALL have port in_word, input, 1 bit: selects 32-bit word mode (RV64 W-instructions).
REQ-012 SHALL have port in_tag, input, TAG_W bits: the tag carried alongside the operation.
REQ-013 SHALL have port flush, input, 1 bit: discards all in-flight operations.
REQ-014 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer accepts the presented result.
REQ-016 SHALL have port out_result, output, XLEN bits: the shifted result.
REQ-017 SHALL have port out_tag, output, TAG_W bits: the tag of the presented result.

Function
REQ-018 SHALL implement the op encodings 00 SLL (logical left), 01 SRL (logical right), 11 SRA (arithmetic right) and 10 reserved; the reserved encoding SHALL produce result 0.
REQ-019 SHALL use the full in_shamt field when in_word=0, giving shift amounts 0..XLEN-1; shift amount 0 SHALL return in_a unchanged.
REQ-020 SHALL, when in_word=1 and XLEN=64, shift in_a[31:0] by in_shamt[4:0], sign-extend bit 31 of the 32-bit result to 64 bits, and perform SRA using in_a[31] as the fill bit.
REQ-021 SHALL ignore in_word when XLEN=32.
REQ-022 SHALL accept an operation on a cycle where in_valid=1 and in_ready=1.
REQ-023 SHALL drive out_valid for an accepted operation exactly STAGES cycles after acceptance when out_ready stays high.
REQ-024 SHALL split the log2(XLEN) shift-by-power-of-two steps across STAGES registered stages, as evenly as possible, with the earliest stages taking any extra steps.
REQ-025 SHALL give each stage its own valid bit and SHALL let a stage advance when the next stage is empty or is advancing in the same cycle.
REQ-026 SHALL compute in_ready = !valid[0] || stage 0 advancing, so one operation per cycle is sustained with out_ready high.
REQ-027 SHALL hold out_result and out_tag stable while out_valid=1 and out_ready=0.
REQ-028 SHALL deliver results in acceptance order and SHALL never drop or duplicate an operation.
REQ-029 SHALL, when flush=1, clear all valid bits at the next clock edge.
REQ-030 SHALL drop an input presented in the same cycle as flush, and SHALL drive in_ready=0 during a flush cycle.
REQ-031 SHALL hold out_valid=0 in the cycle after a flush.

Reset
REQ-032 SHALL, while rst=1, clear all stage valid bits asynchronously so that out_valid=0 and in_ready=1.
REQ-033 SHALL reset data and tag registers to 0.
REQ-034 SHALL lose any operation in flight when reset is asserted mid-operation, and SHALL accept a new operation on the first edge after rst is released.

Structure
REQ-035 SHALL place the shift_op_t typedef (SLL, SRL, SRA, RSVD) and the per-stage step-count function in shared package shift_pkg.
REQ-036 SHALL use one sub-module, shift_stage, instanced STAGES times; each instance is parametrised by its first and last shift step and holds the valid, data, tag, op and fill-bit registers.

Verification
REQ-037 SHALL cover SRL with in_a=0x8000_0000_0000_0000 and shamt=63 -> out_result=0x0000_0000_0000_0001 after 2 cycles (XLEN=64, STAGES=2).
REQ-038 SHALL cover SRA with in_a=0x8000_0000_0000_0000 and shamt=4 -> 0xF800_0000_0000_0000; and SRA with in_a=0x7000_0000_0000_0000 and shamt=4 -> 0x0700_0000_0000_0000.
REQ-039 SHALL cover word mode: SLLW of in_a=0x1 with shamt=31 -> 0xFFFF_FFFF_8000_0000; SRAW of in_a=0x0000_0000_8000_0000 with shamt=31 -> 0xFFFF_FFFF_FFFF_FFFF; SRLW of in_a=0xFFFF_FFFF_FFFF_FFFF with shamt=4 -> 0x0000_0000_0FFF_FFFF.
REQ-040 SHALL cover backpressure: push tags 1..4 back-to-back with out_ready=0 for 6 cycles -> in_ready falls after 2 accepts, then tags 1..4 emerge in order with no loss once out_ready=1.
REQ-041 SHALL cover flush: flush asserted with 2 operations in flight plus one input offered in the same cycle -> no out_valid from any of the three, and a subsequent operation completes normally.
REQ-042 SHALL cover reset mid-operation: assert rst with 2 operations in flight -> out_valid=0 immediately and in_ready=1, and no stale result appears after release.
